// File: rtl/parent.sv
// -----------------------------------------------------------------------------
// parent: caregiver-side FSM that answers the kid's meal request line.
//
// Flow: IDLE -> COOK (COOK_CYCLES) -> SERVE (meal pulse) -> WAIT_FULL
//       -> READ (READ_GAP) -> BOOK (book pulse) -> IDLE.
// An empty pantry diverts a request to SHOP (RESTOCK_CYCLES), which refills
// the pantry and returns to IDLE so the request is evaluated again.
//
// Handshake: request is a level. A high request sampled in IDLE commits one
// order; the order completes even if request falls while cooking. The FSM
// then waits for request to be sampled low (kid is full) before reading and
// pulsing book. meal and book are one-cycle pulses decoded from state only.
//
// Ports:
//   clk           in   rising-edge clock
//   resetb        in   synchronous reset, active high (1 = in reset)
//   request       in   kid's registered meal request (level)
//   meal          out  one-cycle serve pulse
//   book          out  one-cycle book pulse
//   busy          out  high in any state other than IDLE
//   pantry_level  out  meals remaining (4 bits)
//   meals_served  out  total meals served, wraps 255 -> 0
//   state_o       out  current FSM state (debug visibility; IDLE = 0)
//
// Optional feature macro: PARENT_STATS_EN
//   defined   -> meals_served counter is built
//   undefined -> no counter flops, meals_served tied to 8'd0
// -----------------------------------------------------------------------------
module parent #(
  parameter int unsigned COOK_CYCLES    = 3,
  parameter int unsigned READ_GAP       = 2,
  parameter int unsigned PANTRY         = 7,
  parameter int unsigned RESTOCK_CYCLES = 8
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic       request,
  output logic       meal,
  output logic       book,
  output logic       busy,
  output logic [3:0] pantry_level,
  output logic [7:0] meals_served,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COOK      = 3'd1,
    SERVE     = 3'd2,
    WAIT_FULL = 3'd3,
    READ      = 3'd4,
    BOOK      = 3'd5,
    SHOP      = 3'd6
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] pantry_q, pantry_d;

  always_ff @(posedge clk) begin
    if (resetb) begin
      state_q  <= IDLE;
      cnt_q    <= 8'd0;
      pantry_q <= 4'(PANTRY);
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pantry_q <= pantry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    pantry_d = pantry_q;
    case (state_q)
      IDLE: begin
        if (request) begin
          if (pantry_q != 4'd0) begin
            state_d = COOK;
            cnt_d   = 8'(COOK_CYCLES - 1);
          end else begin
            state_d = SHOP;
            cnt_d   = 8'(RESTOCK_CYCLES - 1);
          end
        end
      end
      // request is deliberately ignored here: an order is never aborted.
      COOK: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = SERVE;
      end
      // SERVE is only entered with a non-empty pantry, so no underflow.
      SERVE: begin
        pantry_d = pantry_q - 4'd1;
        state_d  = WAIT_FULL;
      end
      // Absorbs the kid's one-cycle lag in dropping request.
      WAIT_FULL: begin
        if (!request) begin
          state_d = READ;
          cnt_d   = 8'(READ_GAP - 1);
        end
      end
      READ: begin
        if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
        else               state_d = BOOK;
      end
      BOOK: state_d = IDLE;
      SHOP: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          pantry_d = 4'(PANTRY);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign meal         = (state_q == SERVE);
  assign book         = (state_q == BOOK);
  assign busy         = (state_q != IDLE);
  assign pantry_level = pantry_q;
  assign state_o      = state_q;

`ifdef PARENT_STATS_EN
  logic [7:0] served_q;

  // Counts on the SERVE cycle so the total updates together with the pantry.
  always_ff @(posedge clk) begin
    if (resetb)                served_q <= 8'd0;
    else if (state_q == SERVE) served_q <= served_q + 8'd1;
  end

  assign meals_served = served_q;
`else
  assign meals_served = 8'd0;
`endif

endmodule

// File: tb/tb_parent.sv
// -----------------------------------------------------------------------------
// tb_parent: directed self-checking bench for parent (default parameters).
// The bench plays the kid: raise request, wait for meal, hold or drop request,
// wait for book. Expected pulse edges are queued when request changes and
// popped when the pulse appears. Outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_parent;

  localparam int COOK    = 3;
  localparam int GAP     = 2;
  localparam int PANTRY  = 7;
  localparam int RESTOCK = 8;

  logic       clk;
  logic       resetb;
  logic       request;
  logic       meal;
  logic       book;
  logic       busy;
  logic [3:0] pantry_level;
  logic [7:0] meals_served;
  logic [2:0] state_o;

  int          n_cmp;
  int          n_fail;
  int          cyc;
  bit          running;
  logic [31:0] exp_q[$];
  int          pantry_m;
  logic [7:0]  served_m;

  parent #(
    .COOK_CYCLES   (COOK),
    .READ_GAP      (GAP),
    .PANTRY        (PANTRY),
    .RESTOCK_CYCLES(RESTOCK)
  ) dut (
    .clk         (clk),
    .resetb      (resetb),
    .request     (request),
    .meal        (meal),
    .book        (book),
    .busy        (busy),
    .pantry_level(pantry_level),
    .meals_served(meals_served),
    .state_o     (state_o)
  );

  // ---------------- clock / reset block ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- checking helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_served();
`ifdef PARENT_STATS_EN
    return served_m;
`else
    return 8'd0;
`endif
  endfunction

  // meal and book must never coincide.
  always @(negedge clk) begin
    if (running) begin
      n_cmp++;
      assert (!(meal && book)) else begin
        n_fail++;
        $error("FAIL meal_book_overlap observed=1 expected=0");
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    resetb  = 1'b1;
    request = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetb = 1'b0;
    pantry_m = PANTRY;
    served_m = 8'd0;
  endtask

  // One full round as the kid. hold = extra cycles request stays high after
  // the meal (FSM must park in WAIT_FULL).
  task automatic do_meal(input int hold);
    bit          shop;
    bit          found;
    int          e0;
    int          f0;
    logic [31:0] exp_edge;
    shop = (pantry_m == 0);
    @(posedge clk); #1;
    request = 1'b1;
    e0 = cyc + 1;
    exp_q.push_back(32'(shop ? e0 + RESTOCK + 1 + COOK : e0 + COOK));

    if (shop) begin
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (cyc == e0 + RESTOCK) break;
      end
      check("restock_level", 32'(pantry_level), 32'(PANTRY));
      check("restock_idle_busy", 32'(busy), 32'd0);
      pantry_m = PANTRY;
    end

    found = 1'b0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if (meal) found = 1'b1;
    end
    check("meal_seen", 32'(found), 32'd1);
    exp_edge = exp_q.pop_front();
    if (found) check("meal_edge", 32'(cyc), exp_edge);
    pantry_m = pantry_m - 1;
    served_m = served_m + 8'd1;

    @(negedge clk);
    check("meal_width", 32'(meal), 32'd0);
    check("pantry_after_serve", 32'(pantry_level), 32'(pantry_m));
    check("served_after_serve", 32'(meals_served), 32'(exp_served()));
    check("busy_wait_full", 32'(busy), 32'd1);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("park_busy", 32'(busy), 32'd1);
      check("park_no_book", 32'(book), 32'd0);
    end

    @(posedge clk); #1;
    request = 1'b0;
    f0 = cyc + 1;
    exp_q.push_back(32'(f0 + GAP));

    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (book) found = 1'b1;
    end
    check("book_seen", 32'(found), 32'd1);
    exp_edge = exp_q.pop_front();
    if (found) check("book_edge", 32'(cyc), exp_edge);

    @(negedge clk);
    check("book_width", 32'(book), 32'd0);
    check("idle_after_book", 32'(busy), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp    = 0;
    n_fail   = 0;
    running  = 1'b0;
    resetb   = 1'b1;
    request  = 1'b0;
    pantry_m = PANTRY;
    served_m = 8'd0;

    // Reset state
    do_reset();
    running = 1'b1;
    @(negedge clk);
    check("rst_meal", 32'(meal), 32'd0);
    check("rst_book", 32'(book), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pantry", 32'(pantry_level), 32'(PANTRY));
    check("rst_served", 32'(meals_served), 32'd0);

    // Single meal, then a round parked in WAIT_FULL, then a plain round
    do_meal(0);
    do_meal(5);
    do_meal(0);
    check("pantry_after_3", 32'(pantry_level), 32'd4);

    // Reset during COOK with cnt = 1
    @(posedge clk); #1;
    request = 1'b1;
    @(posedge clk);           // E0: IDLE -> COOK, cnt = 2
    @(posedge clk);           // E0+1: cnt = 1
    #1;
    check("cook_busy", 32'(busy), 32'd1);
    resetb  = 1'b1;
    request = 1'b0;
    @(posedge clk); #1;       // E0+2: reset sampled
    resetb   = 1'b0;
    pantry_m = PANTRY;
    served_m = 8'd0;
    @(negedge clk);
    check("midcook_busy", 32'(busy), 32'd0);
    check("midcook_state", 32'(state_o), 32'd0);
    check("midcook_pantry", 32'(pantry_level), 32'(PANTRY));
    check("midcook_served", 32'(meals_served), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("midcook_no_meal", 32'(meal), 32'd0);
    end

    // Pantry exhaustion: 7 meals empty it, the 8th goes through SHOP
    for (int i = 0; i < PANTRY; i++) do_meal(0);
    check("pantry_empty", 32'(pantry_level), 32'd0);
    do_meal(0);
    check("pantry_after_shop", 32'(pantry_level), 32'(PANTRY - 1));

    // 256 serves from reset: counter wraps to 0 (or stays 0 without stats)
    do_reset();
    for (int i = 0; i < 256; i++) begin
      do_meal(i % 17 == 3 ? 1 : 0);
      if (i == 127) check("served_mid", 32'(meals_served), 32'(exp_served()));
    end
    check("served_wrap", 32'(meals_served), 32'(exp_served()));
`ifdef PARENT_STATS_EN
    check("served_wrap_zero", 32'(meals_served), 32'd0);
`endif
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    running = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
